// File: rtl/pool_result_store_pkg.sv
// Shared constants and state encoding for the pooled-result store.
package pool_result_store_pkg;

  localparam int unsigned BITWIDTH    = 17;
  localparam int unsigned MAP_WIDTH   = 14;
  localparam int unsigned MAP_HEIGHT  = 14;
  localparam int unsigned MAP_CHANNEL = 6;
  localparam int unsigned FRAC_BITS   = 8;

  localparam int unsigned MAP_SIZE = MAP_WIDTH * MAP_HEIGHT * MAP_CHANNEL;

  function automatic int unsigned calc_addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int unsigned ADDR_W = calc_addr_w(MAP_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/relu_requant.sv
// ReLU followed by truncating right shift and saturation to a non-negative bitwidth value.
module relu_requant #(
  parameter int unsigned bitwidth  = 17,
  parameter int unsigned frac_bits = 8
) (
  input  logic signed [2*bitwidth-1:0] din,
  output logic        [bitwidth-1:0]   dout
);

  localparam logic signed [2*bitwidth-1:0] MaxPos =
    {{(bitwidth + 1){1'b0}}, {(bitwidth - 1){1'b1}}};

  logic signed [2*bitwidth-1:0] shifted;

  always_comb begin
    shifted = din >>> frac_bits;
    if (din[2*bitwidth-1]) begin
      dout = '0;
    end else if (shifted > MaxPos) begin
      dout = MaxPos[bitwidth-1:0];
    end else begin
      dout = shifted[bitwidth-1:0];
    end
  end

endmodule

// File: rtl/pool_result_store.sv
// Collects pooled results, requantises them and stores the map channel-major in an on-chip RAM.
module pool_result_store
  import pool_result_store_pkg::*;
#(
  parameter int unsigned bitwidth    = BITWIDTH,
  parameter int unsigned map_width   = MAP_WIDTH,
  parameter int unsigned map_height  = MAP_HEIGHT,
  parameter int unsigned map_channel = MAP_CHANNEL,
  parameter int unsigned frac_bits   = FRAC_BITS,
  parameter int unsigned addr_w      = ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [2*bitwidth-1:0] max_number,
  input  logic                         flag_store,
  input  logic                         rd_en,
  input  logic        [addr_w-1:0]     rd_addr,
  output logic        [bitwidth-1:0]   rd_data,
  output logic                         rd_valid,
  output logic        [addr_w:0]       wr_count,
  output logic                         busy,
  output logic                         layer_done,
  output logic                         overflow_err
);

  localparam int unsigned map_size = map_width * map_height * map_channel;
  localparam int unsigned ColW = (map_width > 1) ? $clog2(map_width) : 1;
  localparam int unsigned RowW = (map_height > 1) ? $clog2(map_height) : 1;
  localparam int unsigned ChW  = (map_channel > 1) ? $clog2(map_channel) : 1;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic              s1_valid_q, s1_valid_d;
  logic [bitwidth-1:0] s1_data_q, s1_data_d;
  logic [addr_w-1:0] s1_addr_q, s1_addr_d;
  logic [addr_w:0]   wr_count_q, wr_count_d;
  logic              overflow_q, overflow_d;
  logic [bitwidth-1:0] requant;
  logic              accept, wr_en, last_wr;

  logic [bitwidth-1:0] mem [2**addr_w];

  relu_requant #(
    .bitwidth (bitwidth),
    .frac_bits(frac_bits)
  ) u_relu_requant (
    .din (max_number),
    .dout(requant)
  );

  // start wins over a coincident strobe and drops the stage-1 result.
  assign accept  = flag_store && (state_q == COLLECT) && !start;
  assign wr_en   = s1_valid_q && !start;
  assign last_wr = wr_en && (s1_addr_q == addr_w'(map_size - 1));

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    ch_d       = ch_q;
    s1_valid_d = accept;
    s1_data_d  = s1_data_q;
    s1_addr_d  = s1_addr_q;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;

    if (accept) begin
      s1_data_d = requant;
      s1_addr_d = addr_w'(32'(ch_q) * (map_width * map_height) + 32'(row_q) * map_width
                          + 32'(col_q));
      if (col_q == ColW'(map_width - 1)) begin
        col_d = '0;
        if (row_q == RowW'(map_height - 1)) begin
          row_d = '0;
          ch_d  = (ch_q == ChW'(map_channel - 1)) ? '0 : ch_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (wr_en) wr_count_d = wr_count_q + 1'b1;
    if (flag_store && (state_q != COLLECT)) overflow_d = 1'b1;

    case (state_q)
      IDLE:    state_d = IDLE;
      COLLECT: if (last_wr) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d    = COLLECT;
      col_d      = '0;
      row_d      = '0;
      ch_d       = '0;
      s1_valid_d = 1'b0;
      wr_count_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      ch_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      ch_q       <= ch_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_addr_q  <= s1_addr_d;
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[s1_addr_q] <= s1_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  assign wr_count     = wr_count_q;
  assign busy         = (state_q == COLLECT);
  assign layer_done   = (state_q == DONE);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_pool_result_store.sv
// Directed plus randomized bench for pool_result_store against a value-level buffer model.
module tb_pool_result_store;

  localparam int MapSize = 1176;

  logic               clk = 1'b0;
  logic               reset, start, flag_store, rd_en;
  logic signed [33:0] max_number;
  logic [10:0]        rd_addr;
  logic [16:0]        rd_data;
  logic               rd_valid;
  logic [11:0]        wr_count;
  logic               busy, layer_done, overflow_err;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint model_mem [2048];
  int     model_pos;

  pool_result_store dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .max_number  (max_number),
    .flag_store  (flag_store),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .wr_count    (wr_count),
    .busy        (busy),
    .layer_done  (layer_done),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ReLU, divide by 2^8 with truncation, clamp to 2^16-1.
  function automatic longint requant(input longint x);
    longint v;
    if (x < 0) return 0;
    v = x / 256;
    if (v > 65535) v = 65535;
    return v;
  endfunction

  function automatic longint rand_val();
    case ($urandom_range(0, 2))
      0:       return longint'($urandom_range(0, 1 << 24));
      1:       return -longint'($urandom_range(1, 1 << 20));
      default: return longint'($urandom_range(0, 32'h7fff_ffff)) * 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_pos = 0;
  endtask

  task automatic strobe(input longint x, input bit commit);
    max_number = 34'(x);
    flag_store = 1'b1;
    step();
    flag_store = 1'b0;
    if (commit) model_mem[model_pos] = requant(x);
    model_pos++;
  endtask

  task automatic read_chk(input int a, input longint exp);
    rd_en   = 1'b1;
    rd_addr = 11'(a);
    step();
    rd_en = 1'b0;
    chk($sformatf("rd_valid[%0d]", a), 64'(rd_valid), 64'd1);
    chk($sformatf("rd_data[%0d]", a), 64'(rd_data), 64'(exp));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flag_store = 1'b0; rd_en = 1'b0;
    rd_addr = '0; max_number = '0;
    #12;
    chk("reset rd_data", 64'(rd_data), 64'd0);
    chk("reset rd_valid", 64'(rd_valid), 64'd0);
    chk("reset wr_count", 64'(wr_count), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset layer_done", 64'(layer_done), 64'd0);
    chk("reset overflow_err", 64'(overflow_err), 64'd0);
    step();
    reset = 1'b0;
    step();

    // Requant values: three directed, then random classes.
    pulse_start();
    chk("busy after start", 64'(busy), 64'd1);
    strobe(4660, 1);
    strobe(-500, 1);
    strobe(longint'(1) << 30, 1);
    for (int i = 0; i < 20; i++) strobe(rand_val(), 1);
    step();
    step();
    chk("wr_count 23", 64'(wr_count), 64'd23);
    read_chk(0, 18);
    read_chk(1, 0);
    read_chk(2, 65535);
    for (int a = 3; a < 23; a++) read_chk(a, model_mem[a]);

    // Full map, back-to-back, restarted from COLLECT.
    pulse_start();
    for (int k = 0; k < MapSize; k++) strobe(longint'(k) << 8, 1);
    chk("busy before last commit", 64'(busy), 64'd1);
    chk("layer_done before last commit", 64'(layer_done), 64'd0);
    step();
    chk("layer_done after last commit", 64'(layer_done), 64'd1);
    chk("busy in done", 64'(busy), 64'd0);
    chk("wr_count full", 64'(wr_count), 64'(MapSize));
    read_chk(14, 14);
    read_chk(15, 15);
    read_chk(196, 196);
    read_chk(1175, 1175);
    for (int i = 0; i < 6; i++) begin
      int a;
      a = int'($urandom_range(0, MapSize - 1));
      read_chk(a, model_mem[a]);
    end

    // Strobe in DONE is an overflow, not a write.
    max_number = 34'(99 << 8);
    flag_store = 1'b1;
    step();
    flag_store = 1'b0;
    chk("overflow_err set", 64'(overflow_err), 64'd1);
    step();
    step();
    chk("wr_count held", 64'(wr_count), 64'(MapSize));
    chk("layer_done held", 64'(layer_done), 64'd1);
    read_chk(0, 0);
    pulse_start();
    chk("overflow_err cleared", 64'(overflow_err), 64'd0);
    chk("layer_done cleared", 64'(layer_done), 64'd0);
    chk("busy restart", 64'(busy), 64'd1);
    chk("wr_count cleared", 64'(wr_count), 64'd0);

    // Reset mid-map: the 50th value is still in flight and must be dropped.
    rd_en = 1'b1;
    rd_addr = 11'd1175;
    for (int i = 0; i < 50; i++) strobe(rand_val(), i < 49);
    reset = 1'b1;
    rd_en = 1'b0;
    #1;
    chk("midreset rd_data", 64'(rd_data), 64'd0);
    chk("midreset rd_valid", 64'(rd_valid), 64'd0);
    chk("midreset wr_count", 64'(wr_count), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset layer_done", 64'(layer_done), 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("idle after reset", 64'(busy), 64'd0);
    read_chk(48, model_mem[48]);
    read_chk(49, 49);
    pulse_start();
    strobe(300 << 8, 1);
    step();
    read_chk(0, 300);

    // Read-first on a same-edge read/write collision.
    pulse_start();
    for (int i = 0; i < 5; i++) strobe(rand_val(), 1);
    strobe(7 << 8, 1);
    step();
    step();
    read_chk(5, 7);
    pulse_start();
    for (int i = 0; i < 5; i++) strobe(rand_val(), 1);
    strobe(9 << 8, 1);
    rd_en = 1'b1;
    rd_addr = 11'd5;
    step();
    chk("collision old word", 64'(rd_data), 64'd7);
    step();
    rd_en = 1'b0;
    chk("post-collision new word", 64'(rd_data), 64'd9);
    chk("wr_count after collision", 64'(wr_count), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
